regfile_scoreboard: RTL and testbench

Parametrised successor to the CPU register file: one write port, NUM_READ registered read ports, a hardwired zero register and same-cycle write-to-read forwarding. Adds a per-register pending scoreboard: decode reserves a destination, writeback clears it, and each read port reports whether its operand is ready. Sits between decode (reserve and read) and writeback (write) in the pipeline; replaces the fixed 32x32 two-port file.

---
 rtl/regfile_scoreboard_pkg.sv | 18 +
 rtl/regfile_scoreboard_if.sv | 32 +++
 rtl/regfile_scoreboard_read_port.sv | 45 ++++
 rtl/regfile_scoreboard.sv | 117 +++++++++++
 tb/tb_regfile_scoreboard.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_scoreboard_pkg.sv
// Shared CPU register-file definitions: default geometry, the hardwired zero
// register and the pending-counter update encoding.
package regfile_scoreboard_pkg;

   localparam int DEFAULT_DATA_WIDTH = 32;
   localparam int DEFAULT_ADDR_WIDTH = 5;
   localparam int DEFAULT_NUM_READ   = 2;
   localparam int ZERO_REG           = 0;

   // How the pending counter moves on a given edge.
   typedef enum logic [1:0] {
      CNT_HOLD  = 2'd0,
      CNT_INC   = 2'd1,
      CNT_DEC   = 2'd2,
      CNT_CLEAR = 2'd3
   } countOp_e;

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback bus of the register file. master = pipeline side,
// slave = register file.
interface regfile_scoreboard_if
   import regfile_scoreboard_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
   parameter int NUM_READ   = DEFAULT_NUM_READ
);

   logic [NUM_READ*ADDR_WIDTH-1:0] RegRead;
   logic [ADDR_WIDTH-1:0]          RegWrite;
   logic [DATA_WIDTH-1:0]          DataWrite;
   logic                           WriteEnable;
   logic                           Reserve;
   logic [ADDR_WIDTH-1:0]          ReserveAddr;
   logic                           Flush;
   logic [NUM_READ*DATA_WIDTH-1:0] ReadOut;
   logic [NUM_READ-1:0]            ReadReady;
   logic [ADDR_WIDTH:0]            PendingCount;

   modport master (
      output RegRead, RegWrite, DataWrite, WriteEnable, Reserve, ReserveAddr, Flush,
      input  ReadOut, ReadReady, PendingCount
   );

   modport slave (
      input  RegRead, RegWrite, DataWrite, WriteEnable, Reserve, ReserveAddr, Flush,
      output ReadOut, ReadReady, PendingCount
   );

endinterface

// File: rtl/regfile_scoreboard_read_port.sv
// One registered read port: zero-register check, optional same-cycle write
// forwarding and operand-ready computation from the pre-edge pending bit.
module regfile_read_port
   import regfile_scoreboard_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
   parameter bit BYPASS     = 1'b1
) (
   input  logic                  CLOCK,
   input  logic                  RESET,
   input  logic [ADDR_WIDTH-1:0] readAddr,
   input  logic [DATA_WIDTH-1:0] storedData,
   input  logic                  storedPending,
   input  logic                  writeEnable,
   input  logic [ADDR_WIDTH-1:0] writeAddr,
   input  logic [DATA_WIDTH-1:0] writeData,
   output logic [DATA_WIDTH-1:0] readData,
   output logic                  readReady
);

   logic isZero;
   logic writeHit;

   assign isZero   = (readAddr == ADDR_WIDTH'(ZERO_REG));
   assign writeHit = writeEnable && (writeAddr == readAddr);

   // Register operand data and readiness; a same-cycle writeback always makes
   // the operand ready, even when its data is not forwarded.
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         readData  <= '0;
         readReady <= 1'b0;
      end else begin
         readReady <= isZero || !storedPending || writeHit;
         if (isZero)
            readData <= '0;
         else if (BYPASS && writeHit)
            readData <= writeData;
         else
            readData <= storedData;
      end
   end

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with one write port, NUM_READ registered read ports and a
// per-register pending scoreboard (decode reserves, writeback clears).
module regfile_scoreboard
   import regfile_scoreboard_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
   parameter int NUM_READ   = DEFAULT_NUM_READ,
   parameter bit BYPASS     = 1'b1
) (
   input  logic               CLOCK,
   input  logic               RESET,
   regfile_scoreboard_if.slave bus
);

   localparam int DEPTH = 2**ADDR_WIDTH;

   logic [DATA_WIDTH-1:0]          regFile [DEPTH];
   logic [DEPTH-1:0]               pending;
   logic [DEPTH-1:0]               pendingNext;
   logic [ADDR_WIDTH:0]            pendingCount;
   logic                           writeValid;
   logic                           reserveValid;
   logic                           reserveSet;
   logic                           writeClear;
   countOp_e                       countOp;
   logic [NUM_READ*DATA_WIDTH-1:0] readOutBus;
   logic [NUM_READ-1:0]            readReadyBus;

   assign writeValid   = bus.WriteEnable && (bus.RegWrite != ADDR_WIDTH'(ZERO_REG));
   assign reserveValid = bus.Reserve && (bus.ReserveAddr != ADDR_WIDTH'(ZERO_REG));

   // Counter events mirror the pending-bit transitions exactly: a reserve only
   // counts if the bit was clear, a write only counts if it actually clears it.
   assign reserveSet = reserveValid && !bus.Flush && !pending[bus.ReserveAddr];
   assign writeClear = writeValid && !bus.Flush && pending[bus.RegWrite]
                       && !(reserveValid && (bus.ReserveAddr == bus.RegWrite));

   // Next pending vector: flush wins, then reserve overrides a same-cycle write.
   always_comb begin
      pendingNext = pending;
      if (bus.Flush) begin
         pendingNext = '0;
      end else begin
         if (writeValid)
            pendingNext[bus.RegWrite] = 1'b0;
         if (reserveValid)
            pendingNext[bus.ReserveAddr] = 1'b1;
      end
      pendingNext[ZERO_REG] = 1'b0;
   end

   // Pick the counter update for this edge.
   always_comb begin
      countOp = CNT_HOLD;
      if (bus.Flush)
         countOp = CNT_CLEAR;
      else if (reserveSet && !writeClear)
         countOp = CNT_INC;
      else if (writeClear && !reserveSet)
         countOp = CNT_DEC;
   end

   // Scoreboard state: pending bits and their running population count.
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         pending      <= '0;
         pendingCount <= '0;
      end else begin
         pending <= pendingNext;
         unique case (countOp)
            CNT_HOLD:  pendingCount <= pendingCount;
            CNT_INC:   pendingCount <= pendingCount + (ADDR_WIDTH+1)'(1);
            CNT_DEC:   pendingCount <= pendingCount - (ADDR_WIDTH+1)'(1);
            CNT_CLEAR: pendingCount <= '0;
            default:   pendingCount <= '0;
         endcase
      end
   end

   // Storage array; entry 0 is never written so it stays zero.
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         for (int r = 0; r < DEPTH; r++)
            regFile[r] <= '0;
      end else if (writeValid) begin
         regFile[bus.RegWrite] <= bus.DataWrite;
      end
   end

   for (genvar i = 0; i < NUM_READ; i++) begin : gReadPort
      logic [ADDR_WIDTH-1:0] portAddr;
      assign portAddr = bus.RegRead[i*ADDR_WIDTH +: ADDR_WIDTH];

      regfile_read_port #(
         .DATA_WIDTH (DATA_WIDTH),
         .ADDR_WIDTH (ADDR_WIDTH),
         .BYPASS     (BYPASS)
      ) uReadPort (
         .CLOCK         (CLOCK),
         .RESET         (RESET),
         .readAddr      (portAddr),
         .storedData    (regFile[portAddr]),
         .storedPending (pending[portAddr]),
         .writeEnable   (bus.WriteEnable),
         .writeAddr     (bus.RegWrite),
         .writeData     (bus.DataWrite),
         .readData      (readOutBus[i*DATA_WIDTH +: DATA_WIDTH]),
         .readReady     (readReadyBus[i])
      );
   end

   assign bus.ReadOut      = readOutBus;
   assign bus.ReadReady    = readReadyBus;
   assign bus.PendingCount = pendingCount;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench: a forwarding instance (A) and a non-forwarding instance (B)
// share one stimulus stream; expected outputs are queued per step and checked
// after the edge.
module tb_regfile_scoreboard;
   import regfile_scoreboard_pkg::*;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NR = 2;

   logic CLOCK;
   logic RESET;

   regfile_scoreboard_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR)) busA ();
   regfile_scoreboard_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR)) busB ();

   regfile_scoreboard #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR), .BYPASS(1'b1)) dutA (
      .CLOCK (CLOCK),
      .RESET (RESET),
      .bus   (busA.slave)
   );

   regfile_scoreboard #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR), .BYPASS(1'b0)) dutB (
      .CLOCK (CLOCK),
      .RESET (RESET),
      .bus   (busB.slave)
   );

   assign busB.RegRead     = busA.RegRead;
   assign busB.RegWrite    = busA.RegWrite;
   assign busB.DataWrite   = busA.DataWrite;
   assign busB.WriteEnable = busA.WriteEnable;
   assign busB.Reserve     = busA.Reserve;
   assign busB.ReserveAddr = busA.ReserveAddr;
   assign busB.Flush       = busA.Flush;

   initial CLOCK = 1'b0;
   always #5 CLOCK = ~CLOCK;

   typedef struct {
      int          step;
      int          kind;
      int          port;
      logic [31:0] val;
   } exp_t;

   exp_t sbq[$];
   int   checks = 0;
   int   errors = 0;
   int   stepNo = 0;

   function automatic string kindName(input int k);
      case (k)
         0: return "A_ReadOut";
         1: return "A_ReadReady";
         2: return "A_PendingCount";
         3: return "B_ReadOut";
         4: return "B_ReadReady";
         5: return "B_PendingCount";
         default: return "unknown";
      endcase
   endfunction

   task automatic pushExp(input int kind, input int port, input logic [31:0] val);
      exp_t e;
      e.step = stepNo;
      e.kind = kind;
      e.port = port;
      e.val  = val;
      sbq.push_back(e);
   endtask

   task automatic expPort(input bit onB, input int port, input logic [31:0] data, input logic ready);
      pushExp(onB ? 3 : 0, port, data);
      pushExp(onB ? 4 : 1, port, {31'd0, ready});
   endtask

   task automatic expCount(input bit onB, input int cnt);
      pushExp(onB ? 5 : 2, 0, 32'(cnt));
   endtask

   task automatic tick();
      exp_t        e;
      logic [31:0] obs;
      @(posedge CLOCK);
      #1;
      while (sbq.size() > 0) begin
         e = sbq.pop_front();
         case (e.kind)
            0:       obs = busA.ReadOut[e.port*DW +: DW];
            1:       obs = 32'(busA.ReadReady[e.port]);
            2:       obs = 32'(busA.PendingCount);
            3:       obs = busB.ReadOut[e.port*DW +: DW];
            4:       obs = 32'(busB.ReadReady[e.port]);
            5:       obs = 32'(busB.PendingCount);
            default: obs = 'x;
         endcase
         checks++;
         assert (obs === e.val) else begin
            errors++;
            $error("FAIL step%0d %s port%0d observed=%h expected=%h",
                   e.step, kindName(e.kind), e.port, obs, e.val);
         end
      end
      stepNo++;
   endtask

   task automatic idle();
      busA.WriteEnable = 1'b0;
      busA.Reserve     = 1'b0;
      busA.Flush       = 1'b0;
   endtask

   task automatic setRead(input int a0, input int a1);
      busA.RegRead = {AW'(a1), AW'(a0)};
   endtask

   task automatic doWrite(input int addr, input logic [31:0] data);
      busA.WriteEnable = 1'b1;
      busA.RegWrite    = AW'(addr);
      busA.DataWrite   = data;
   endtask

   task automatic doReserve(input int addr);
      busA.Reserve     = 1'b1;
      busA.ReserveAddr = AW'(addr);
   endtask

   initial begin
      RESET            = 1'b1;
      busA.RegWrite    = '0;
      busA.DataWrite   = '0;
      busA.ReserveAddr = '0;
      idle();
      setRead(3, 0);

      // reset state
      expPort(0, 0, 32'h0, 1'b0); expPort(0, 1, 32'h0, 1'b0); expCount(0, 0);
      expPort(1, 0, 32'h0, 1'b0); expCount(1, 0);
      tick();

      // first reads after release
      RESET = 1'b0;
      setRead(3, 0);
      expPort(0, 0, 32'h0, 1'b1); expPort(0, 1, 32'h0, 1'b1); expCount(0, 0);
      tick();

      // write r5 while reading it: forwarded on A, old value on B
      doWrite(5, 32'hDEADBEEF); setRead(5, 0);
      expPort(0, 0, 32'hDEADBEEF, 1'b1); expPort(1, 0, 32'h0, 1'b1);
      tick();
      idle(); setRead(5, 0);
      expPort(0, 0, 32'hDEADBEEF, 1'b1); expPort(1, 0, 32'hDEADBEEF, 1'b1);
      tick();

      // writes to r0 are dropped; r0 reads zero
      doWrite(0, 32'h12345678); setRead(0, 0);
      expPort(0, 0, 32'h0, 1'b1); expPort(0, 1, 32'h0, 1'b1); expPort(1, 0, 32'h0, 1'b1);
      tick();
      idle(); doReserve(0); setRead(0, 5);
      expPort(0, 0, 32'h0, 1'b1); expPort(0, 1, 32'hDEADBEEF, 1'b1); expCount(0, 0);
      tick();

      // reserve r7; same-cycle reader still sees it ready
      idle(); doReserve(7); setRead(7, 0);
      expPort(0, 0, 32'h0, 1'b1); expCount(0, 1);
      tick();
      idle(); setRead(7, 0);
      expPort(0, 0, 32'h0, 1'b0); expCount(0, 1);
      tick();

      // writeback of r7 while reading it
      idle(); doWrite(7, 32'h55); setRead(7, 7);
      expPort(0, 0, 32'h55, 1'b1); expPort(0, 1, 32'h55, 1'b1); expCount(0, 0);
      expPort(1, 0, 32'h0, 1'b1); expCount(1, 0);
      tick();
      idle(); setRead(7, 0);
      expPort(0, 0, 32'h55, 1'b1); expPort(1, 0, 32'h55, 1'b1); expCount(0, 0);
      tick();

      // reserve and write r9 on the same edge: stays pending
      idle(); doReserve(9); doWrite(9, 32'h99); setRead(9, 7);
      expPort(0, 0, 32'h99, 1'b1); expPort(0, 1, 32'h55, 1'b1); expCount(0, 1); expCount(1, 1);
      tick();

      // reserve r10 and clear r9 together: count unchanged
      idle(); doReserve(10); doWrite(9, 32'hAA); setRead(9, 10);
      expPort(0, 0, 32'hAA, 1'b1); expPort(0, 1, 32'h0, 1'b1); expCount(0, 1);
      tick();
      idle(); setRead(9, 10);
      expPort(0, 0, 32'hAA, 1'b1); expPort(0, 1, 32'h0, 1'b0); expCount(0, 1);
      tick();
      idle(); doWrite(10, 32'h10); setRead(10, 0);
      expPort(0, 0, 32'h10, 1'b1); expCount(0, 0);
      tick();

      // build up three reservations
      idle(); doReserve(1); setRead(0, 0);
      expCount(0, 1);
      tick();
      idle(); doReserve(2); setRead(1, 0);
      expPort(0, 0, 32'h0, 1'b0); expCount(0, 2);
      tick();
      idle(); doReserve(3); setRead(1, 2);
      expPort(0, 0, 32'h0, 1'b0); expPort(0, 1, 32'h0, 1'b0); expCount(0, 3);
      tick();

      // flush beats a same-cycle reserve of r4
      idle(); busA.Flush = 1'b1; doReserve(4); setRead(3, 4);
      expPort(0, 0, 32'h0, 1'b0); expPort(0, 1, 32'h0, 1'b1); expCount(0, 0); expCount(1, 0);
      tick();
      idle(); setRead(3, 4);
      expPort(0, 0, 32'h0, 1'b1); expPort(0, 1, 32'h0, 1'b1); expCount(0, 0);
      tick();
      idle(); setRead(1, 2);
      expPort(0, 0, 32'h0, 1'b1); expPort(0, 1, 32'h0, 1'b1); expCount(0, 0);
      tick();

      // write to a non-pending register after flush
      idle(); doWrite(3, 32'h33); setRead(3, 0);
      expPort(0, 0, 32'h33, 1'b1); expPort(1, 0, 32'h0, 1'b1); expCount(0, 0);
      tick();
      idle(); setRead(3, 0);
      expPort(0, 0, 32'h33, 1'b1); expCount(0, 0);
      tick();

      // reset while a reservation is outstanding, with competing write/reserve
      idle(); doReserve(2); setRead(5, 0);
      expPort(0, 0, 32'hDEADBEEF, 1'b1); expCount(0, 1);
      tick();
      RESET = 1'b1; idle(); doReserve(6); doWrite(8, 32'h88); setRead(5, 2);
      expPort(0, 0, 32'h0, 1'b0); expPort(0, 1, 32'h0, 1'b0); expCount(0, 0);
      expPort(1, 0, 32'h0, 1'b0); expCount(1, 0);
      tick();
      RESET = 1'b0; idle(); setRead(5, 2);
      expPort(0, 0, 32'h0, 1'b1); expPort(0, 1, 32'h0, 1'b1); expCount(0, 0);
      tick();
      idle(); setRead(8, 6);
      expPort(0, 0, 32'h0, 1'b1); expPort(0, 1, 32'h0, 1'b1); expCount(0, 0);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
